// File: rtl/hyperbus_mem_responder.sv
// Responder end of the hyperbus native memory interface: programmable initial
// latency, then one word per two cycles streamed out of or into an internal RAM.
module hyperbus_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_AW     = 10,
    parameter int LATENCY    = 6,
    parameter int RECOVERY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [DATA_WIDTH-1:0] hbus_dat_i,
    output logic [DATA_WIDTH-1:0] hbus_dat_o,
    input  logic                  hbus_rrq,
    input  logic                  hbus_wrq,
    output logic                  hbus_ready,
    output logic                  hbus_valid,
    output logic                  hbus_busy,
    output logic                  err_o
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("hyperbus_mem_responder: LATENCY must be in 1..255");
    end
    if (RECOVERY < 0 || RECOVERY > 255) begin : g_bad_recovery
        $error("hyperbus_mem_responder: RECOVERY must be in 0..255");
    end

    // Address bits above the RAM depth are intentionally ignored.
    if (ADDR_WIDTH > MEM_AW) begin : g_adr_hi
        logic unused_adr_hi;
        assign unused_adr_hi = ^hbus_adr_i[ADDR_WIDTH-1:MEM_AW];
    end

    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);
    localparam logic [7:0] REC_INIT = 8'(RECOVERY - 1);

    typedef enum logic [2:0] {
        IDLE, LAT, RD_BEAT, RD_GAP, WR_BEAT, WR_GAP, RECOVER
    } state_e;

    state_e                  state_q, state_d;
    logic [MEM_AW-1:0]       ptr_q, ptr_d;
    logic [7:0]              lat_cnt_q, lat_cnt_d;
    logic [7:0]              rec_cnt_q, rec_cnt_d;
    logic                    dir_rd_q, dir_rd_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    mem_we;
    logic                    req_live;

    logic [DATA_WIDTH-1:0]   mem [2**MEM_AW];

    assign req_live = dir_rd_q ? hbus_rrq : hbus_wrq;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lat_cnt_d = lat_cnt_q;
        rec_cnt_d = rec_cnt_q;
        dir_rd_d  = dir_rd_q;
        valid_d   = 1'b0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hbus_rrq || hbus_wrq) begin
                    state_d   = LAT;
                    ptr_d     = hbus_adr_i[MEM_AW-1:0];
                    lat_cnt_d = LAT_INIT;
                    dir_rd_d  = hbus_rrq;
                    err_d     = hbus_rrq && hbus_wrq;
                end
            end
            LAT: begin
                if (lat_cnt_q == '0) begin
                    state_d = dir_rd_q ? RD_BEAT : WR_BEAT;
                    valid_d = dir_rd_q;
                    ready_d = !dir_rd_q;
                    if (dir_rd_q) dat_d = mem[ptr_q];
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            RD_BEAT: begin
                ptr_d   = ptr_q + MEM_AW'(1);
                state_d = RD_GAP;
            end
            WR_BEAT: begin
                mem_we  = 1'b1;
                ptr_d   = ptr_q + MEM_AW'(1);
                state_d = WR_GAP;
            end
            RD_GAP, WR_GAP: begin
                // The request is re-checked only after a full gap cycle, so a
                // registered drop by the initiator never sees an extra beat.
                if (req_live) begin
                    state_d = dir_rd_q ? RD_BEAT : WR_BEAT;
                    valid_d = dir_rd_q;
                    ready_d = !dir_rd_q;
                    if (dir_rd_q) dat_d = mem[ptr_q];
                end else if (RECOVERY == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d   = RECOVER;
                    rec_cnt_d = REC_INIT;
                end
            end
            RECOVER: begin
                if (rec_cnt_q == '0) state_d = IDLE;
                else                 rec_cnt_d = rec_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lat_cnt_q <= '0;
            rec_cnt_q <= '0;
            dir_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lat_cnt_q <= lat_cnt_d;
            rec_cnt_q <= rec_cnt_d;
            dir_rd_q  <= dir_rd_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    // NOTE: the RAM has no reset so it maps onto block/distributed memory; rst only gates the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr_q] <= hbus_dat_i;
    end

    assign hbus_dat_o = dat_q;
    assign hbus_valid = valid_q;
    assign hbus_ready = ready_q;
    assign hbus_busy  = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Bench for hyperbus_mem_responder: table of bursts plus random bursts, each cycle
// compared against a beat schedule computed from latency/recovery arithmetic.
module tb_hyperbus_mem_responder;

    localparam int L  = 6;
    localparam int R  = 2;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hbus_adr_i = '0;
    logic [15:0] hbus_dat_i = '0;
    logic [15:0] hbus_dat_o;
    logic        hbus_rrq = 1'b0;
    logic        hbus_wrq = 1'b0;
    logic        hbus_ready, hbus_valid, hbus_busy, err_o;

    hyperbus_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(16), .MEM_AW(AW), .LATENCY(L), .RECOVERY(R)
    ) dut (
        .clk(clk), .rst(rst),
        .hbus_adr_i(hbus_adr_i), .hbus_dat_i(hbus_dat_i), .hbus_dat_o(hbus_dat_o),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid),
        .hbus_busy(hbus_busy), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] adr;
        int          n;
        bit          drop_lat;
        int          abort_at;
        bit          early;
        logic [3:0][15:0] wd;
    } vec_t;

    logic [15:0] model [2**AW];
    logic [15:0] exp_dat = '0;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [19:0] outs();
        return {err_o, hbus_busy, hbus_valid, hbus_ready, hbus_dat_o};
    endfunction

    task automatic check(input string name, input int k, input logic [19:0] got, input logic [19:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got{err,busy,valid,ready,dat}=%h expected=%h", name, k, got, exp);
        end
    endtask

    // Cycle k is the cycle beginning k edges after the accepting edge.
    task automatic run_txn(input string name, input vec_t v);
        int neff = v.drop_lat ? 1 : v.n;
        int last = L + 2 * neff + R;
        hbus_rrq   = v.rd;
        hbus_wrq   = v.wr;
        hbus_adr_i = v.adr;
        @(posedge clk);
        for (int k = 0; k <= last; k++) begin
            bit beat, ev, er, eb, ee;
            int j;
            logic [AW-1:0] wa;
            logic [15:0] w;
            @(negedge clk);
            beat = (k >= L) && (k < L + 2 * neff) && ((k - L) % 2 == 0);
            j    = (k - L) / 2;
            wa   = v.adr[AW-1:0] + AW'(j);
            ev   = beat && v.rd;
            er   = beat && !v.rd;
            eb   = (k < L + 2 * neff + R);
            ee   = (k == 0) && v.rd && v.wr;
            if (ev) exp_dat = model[wa];
            check(name, k, outs(), {ee, eb, ev, er, exp_dat});
            if (er) begin
                w = (j < 4) ? v.wd[j] : 16'($urandom);
                hbus_dat_i = w;
                model[wa]  = w;
            end
            if ((v.drop_lat && k == 0) || (!v.drop_lat && beat && j == neff - 1)) begin
                hbus_rrq = 1'b0;
                hbus_wrq = 1'b0;
            end
            if (v.early && k == L + 2 * neff) begin
                hbus_rrq   = v.rd;
                hbus_wrq   = v.wr;
                hbus_adr_i = v.adr;
            end
            if (v.abort_at > 0 && k == L + 2 * v.abort_at - 1) begin
                rst      = 1'b1;
                hbus_rrq = 1'b0;
                hbus_wrq = 1'b0;
                @(negedge clk);
                exp_dat = '0;
                check({name, "_rst"}, k + 1, outs(), 20'h0);
                rst = 1'b0;
                return;
            end
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] adr, int n, bit dl, int ab, bit e,
                                logic [63:0] wd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.adr = adr; v.n = n;
        v.drop_lat = dl; v.abort_at = ab; v.early = e; v.wd = wd;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        vec_t v;
        int sel;

        tbl[0]  = mk(0, 1, 32'h0000_0010, 2, 0, 0, 0, 64'h0000_0000_BEEF_DEAD);
        tbl[1]  = mk(1, 0, 32'h0000_0010, 2, 0, 0, 0, 64'h0);
        tbl[2]  = mk(1, 0, 32'h0000_0000, 1, 0, 0, 0, 64'h0);
        tbl[3]  = mk(0, 1, 32'h0000_03FF, 3, 0, 0, 0, 64'h0000_0003_0002_0001);
        tbl[4]  = mk(1, 0, 32'h0000_03FF, 3, 0, 0, 0, 64'h0);
        tbl[5]  = mk(1, 1, 32'h0000_0010, 2, 0, 0, 0, 64'h1111_2222_3333_4444);
        tbl[6]  = mk(0, 1, 32'h0000_0020, 3, 1, 0, 0, 64'h0000_0000_0000_5A5A);
        tbl[7]  = mk(1, 0, 32'hABCD_0020, 2, 0, 0, 0, 64'h0);
        tbl[8]  = mk(1, 0, 32'h0000_0010, 1, 0, 0, 1, 64'h0);
        tbl[9]  = mk(1, 0, 32'h0000_0010, 1, 0, 0, 0, 64'h0);
        tbl[10] = mk(0, 1, 32'h0000_0040, 4, 0, 2, 0, 64'hA4A4_A3A3_A2A2_A1A1);
        tbl[11] = mk(1, 0, 32'h0000_0040, 4, 0, 0, 0, 64'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, outs(), 20'h0);
        rst = 1'b0;

        // Fill the whole RAM so every later read has a known expected word.
        run_txn("init_fill", mk(0, 1, 32'h0, 2**AW, 0, 0, 0, {$urandom, $urandom}));

        for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 4);
            v = mk(sel <= 1 || sel == 4, sel >= 2, $urandom, $urandom_range(1, 6),
                   $urandom_range(0, 7) == 0, 0, 0, {$urandom, $urandom});
            run_txn($sformatf("rand%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
